// File: rtl/row_deskew_buffer.sv
`default_nettype none
// ============================================================================
// Module   : row_deskew_buffer
// Purpose  : Rebuilds aligned rows from the diagonally skewed systolic-array
//            stream and queues them in a circular row buffer (valid/ready out).
// Options  : ROW_DESKEW_PAD_CHK_EN adds a sticky pad_err output.
// Revision : 1.0 - initial release
// ============================================================================
module row_deskew_buffer #(
   parameter int INPUT_WIDTH = 8,
   parameter int MATRIX_SIZE = 3,
   parameter int DEPTH_TILES = 2
) (
   input  logic                                          clk,
   input  logic                                          reset_n,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [MATRIX_SIZE*INPUT_WIDTH-1:0]            in_data,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [MATRIX_SIZE*INPUT_WIDTH-1:0]            out_data,
   output logic                                          out_last,
   output logic [$clog2(DEPTH_TILES*MATRIX_SIZE+1)-1:0]  occupancy
`ifdef ROW_DESKEW_PAD_CHK_EN
   ,
   output logic                                          pad_err
`endif
);

   localparam int W     = INPUT_WIDTH;
   localparam int M     = MATRIX_SIZE;
   localparam int S     = DEPTH_TILES * MATRIX_SIZE;
   localparam int CNT_W = $clog2(S + 1);
   localparam int PTR_W = (S > 1) ? $clog2(S) : 1;
   localparam int B_W   = (2*M - 1 > 1) ? $clog2(2*M - 1) : 1;
   localparam int R_W   = (M > 1) ? $clog2(M) : 1;

   localparam logic [CNT_W-1:0] c_m          = CNT_W'(M);
   localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_alloc_max  = CNT_W'(S - M);
   localparam logic [B_W-1:0]   c_span       = B_W'(M);
   localparam logic [B_W-1:0]   c_first_done = B_W'(M - 1);
   localparam logic [B_W-1:0]   c_last_beat  = B_W'(2*M - 2);
   localparam logic [PTR_W-1:0] c_slot_last  = PTR_W'(S - 1);
   localparam logic [PTR_W:0]   c_slots      = (PTR_W+1)'(S);
   localparam logic [PTR_W:0]   c_tile_step  = (PTR_W+1)'(M);
   localparam logic [R_W-1:0]   c_row_last   = R_W'(M - 1);

   logic [M*W-1:0]   slot_q [S];
   logic [M*W-1:0]   slot_d [S];
   logic [B_W-1:0]   b_q, b_d;
   logic [PTR_W-1:0] wr_base_q, wr_base_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [R_W-1:0]   rd_row_q, rd_row_d;
   logic [CNT_W-1:0] alloc_q, alloc_d;
   logic [CNT_W-1:0] complete_q, complete_d;
   logic [M*W-1:0]   hold_q, hold_d;

   logic             accept;
   logic             pop;
   logic             tile_start;
   logic             row_done;
   logic             tile_end;
   logic [PTR_W:0]   base_sum;
   logic [M-1:0]     lane_win;
   logic [PTR_W-1:0] lane_idx [M];

   // Per-lane diagonal window and target slot: lane j carries row b-j on beat b.
   for (genvar j = 0; j < M; j++) begin : g_lane
      localparam logic [B_W-1:0] c_lo = B_W'(j);
      logic [B_W-1:0] off;
      logic [PTR_W:0] sum;
      assign off         = b_q - c_lo;
      assign lane_win[j] = (off < c_span);
      assign sum         = {1'b0, wr_base_q} + (PTR_W+1)'(off);
      assign lane_idx[j] = (sum >= c_slots) ? PTR_W'(sum - c_slots) : sum[PTR_W-1:0];
   end

   assign in_ready   = (b_q != '0) | (alloc_q <= c_alloc_max);
   assign out_valid  = (complete_q != '0);
   assign out_data   = out_valid ? slot_q[rd_ptr_q] : hold_q;
   assign out_last   = (rd_row_q == c_row_last);
   assign occupancy  = alloc_q;

   assign accept     = in_valid & in_ready;
   assign pop        = out_valid & out_ready;
   assign tile_start = accept & (b_q == '0);
   assign row_done   = accept & (b_q >= c_first_done);
   assign tile_end   = accept & (b_q == c_last_beat);
   assign base_sum   = {1'b0, wr_base_q} + c_tile_step;

   always_comb begin
      slot_d = slot_q;
      for (int j = 0; j < M; j++) begin
         if (accept && lane_win[j]) begin
            slot_d[lane_idx[j]][(M-j)*W-1 -: W] = in_data[(M-j)*W-1 -: W];
         end
      end

      b_d = b_q;
      if (accept) begin
         b_d = tile_end ? '0 : b_q + 1'b1;
      end

      wr_base_d = wr_base_q;
      if (tile_end) begin
         wr_base_d = (base_sum >= c_slots) ? PTR_W'(base_sum - c_slots) : base_sum[PTR_W-1:0];
      end

      rd_ptr_d = rd_ptr_q;
      rd_row_d = rd_row_q;
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == c_slot_last) ? '0 : rd_ptr_q + 1'b1;
         rd_row_d = (rd_row_q == c_row_last) ? '0 : rd_row_q + 1'b1;
      end

      alloc_d = alloc_q + (tile_start ? c_m : '0) - (pop ? c_one : '0);

      case ({row_done, pop})
         2'b10:   complete_d = complete_q + c_one;
         2'b01:   complete_d = complete_q - c_one;
         default: complete_d = complete_q;
      endcase

      hold_d = out_valid ? out_data : hold_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < S; i++) begin
            slot_q[i] <= '0;
         end
         b_q        <= '0;
         wr_base_q  <= '0;
         rd_ptr_q   <= '0;
         rd_row_q   <= '0;
         alloc_q    <= '0;
         complete_q <= '0;
         hold_q     <= '0;
      end else begin
         slot_q     <= slot_d;
         b_q        <= b_d;
         wr_base_q  <= wr_base_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_row_q   <= rd_row_d;
         alloc_q    <= alloc_d;
         complete_q <= complete_d;
         hold_q     <= hold_d;
      end
   end

`ifdef ROW_DESKEW_PAD_CHK_EN
   logic pad_err_q, pad_err_d;
   logic pad_hot;

   always_comb begin
      pad_hot = 1'b0;
      for (int j = 0; j < M; j++) begin
         if (!lane_win[j] && (in_data[(M-j)*W-1 -: W] != '0)) begin
            pad_hot = 1'b1;
         end
      end
      pad_err_d = pad_err_q | (accept & pad_hot);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pad_err_q <= 1'b0;
      end else begin
         pad_err_q <= pad_err_d;
      end
   end

   assign pad_err = pad_err_q;
`endif

endmodule
`default_nettype wire
